// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port arbiter: pipeline WB writes take priority, multi-cycle results
// drain from an in-order queue, with WAW squash, starvation stall and pending-destination hits.
module reg_writeback_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_waddr,
    input  logic [31:0] aux_wdata,
    output logic        pipe_stall,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        pend_rs_hit,
    output logic        pend_rt_hit,
    output logic        RegWrite,
    output logic [4:0]  WriteAddr,
    output logic [31:0] WriteData
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_live;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic [SW-1:0]    r_starve;
    logic             r_stall;

    logic             w_pipe_eff;
    logic             w_head_valid;
    logic             w_head_live;
    logic             w_head_wr;
    logic             w_pop;
    logic             w_push;
    logic             w_full;
    logic             w_blocked;
    logic [DEPTH-1:0] w_squash;

    assign pipe_stall = r_stall;

    always_comb begin
        w_pipe_eff   = rst_n & pipe_wen & (pipe_waddr != 5'd0);
        w_head_valid = r_valid[r_rd_ptr];
        w_head_live  = r_live[r_rd_ptr];
        w_head_wr    = w_head_valid & w_head_live & ~w_pipe_eff;
        // A dead (squashed) head is discarded in one cycle without touching the write port.
        w_pop        = w_head_valid & (~w_head_live | ~w_pipe_eff);
        w_full       = (r_count == (AW+1)'(DEPTH));
        aux_ready    = rst_n & ~w_full;
        w_push       = aux_valid & aux_ready & (aux_waddr != 5'd0);

        pend_rs_hit  = 1'b0;
        pend_rt_hit  = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_squash[i] = w_pipe_eff & r_valid[i] & r_live[i] & (r_addr[i] == pipe_waddr);
            if (r_valid[i] && r_live[i] && rs_addr != 5'd0 && r_addr[i] == rs_addr)
                pend_rs_hit = rst_n;
            if (r_valid[i] && r_live[i] && rt_addr != 5'd0 && r_addr[i] == rt_addr)
                pend_rt_hit = rst_n;
        end
        w_blocked = w_head_valid & w_head_live & w_pipe_eff & ~w_squash[r_rd_ptr];

        RegWrite  = 1'b0;
        WriteAddr = '0;
        WriteData = '0;
        if (w_pipe_eff) begin
            RegWrite  = 1'b1;
            WriteAddr = pipe_waddr;
            WriteData = pipe_wdata;
        end else if (w_head_wr) begin
            RegWrite  = 1'b1;
            WriteAddr = r_addr[r_rd_ptr];
            WriteData = r_data[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_valid  <= '0;
            r_live   <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_squash[i])
                    r_live[i] <= 1'b0;
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_live[r_rd_ptr]  <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            // Written after the squash loop so a same-cycle push is never squashed.
            if (w_push) begin
                r_addr[r_wr_ptr]  <= aux_waddr;
                r_data[r_wr_ptr]  <= aux_wdata;
                r_valid[r_wr_ptr] <= 1'b1;
                r_live[r_wr_ptr]  <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_stall <= 1'b0;
            if (w_blocked) begin
                if (r_starve == SW'(STARVE_LIMIT - 1)) begin
                    r_starve <= '0;
                    r_stall  <= 1'b1;
                end else begin
                    r_starve <= r_starve + 1'b1;
                end
            end else begin
                r_starve <= '0;
            end
        end
    end
endmodule
